v_query_scan: RTL and testbench

- Initiator side of the List Query Bus. Accepts a "dump list" request for one product ID.
- Walks every level 0..ENTRIES_N-1 through the query pipeline, one query per cycle where credits allow.
- Streams each valid {level, key, size} to a downstream consumer over a valid/ready interface.
- On completion, reports the entry count and a consistency flag so the caller can retry when updates raced the scan.

---
 rtl/v_query_scan.sv | 142 ++++++++++++++
 tb/tb_v_query_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/v_query_scan.sv
// v_query_scan: List Query Bus initiator that walks every level of one product list and streams the valid entries.
package v_pkg;
  localparam int ENTRIES_N = 16;
  typedef logic [7:0] id_t;
  typedef logic [$clog2(ENTRIES_N)-1:0] level_t;
  typedef logic [15:0] key_t;
  typedef logic [15:0] volume_t;
  typedef logic [$clog2(ENTRIES_N+1)-1:0] listsize_t;
endpackage

module v_query_scan #(
  parameter int ENTRIES_N = v_pkg::ENTRIES_N,
  parameter int OUT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_vld,
  input  v_pkg::id_t            i_req_prod_id,
  output logic                  o_req_rdy,
  output logic                  o_lut_vld,
  output v_pkg::id_t            o_lut_prod_id,
  output v_pkg::level_t         o_lut_level,
  input  v_pkg::key_t           i_lut_key,
  input  v_pkg::volume_t        i_lut_size,
  input  logic                  i_lut_error,
  input  v_pkg::listsize_t      i_lut_listsize,
  output logic                  o_ent_vld,
  output v_pkg::level_t         o_ent_level,
  output v_pkg::key_t           o_ent_key,
  output v_pkg::volume_t        o_ent_size,
  input  logic                  i_ent_rdy,
  output logic                  o_done_vld,
  output v_pkg::listsize_t      o_done_cnt,
  output logic                  o_done_mismatch,
  output logic                  o_busy
);
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int OW = $clog2(OUT_DEPTH + 1);
  typedef struct packed {
    v_pkg::level_t  level;
    v_pkg::key_t    key;
    v_pkg::volume_t size;
  } ent_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  v_pkg::id_t       prod_q, prod_d;
  v_pkg::level_t    lvl_q, lvl_d, lut_lvl_q, lut_lvl_d, infl_lvl_q, infl_lvl_d;
  logic             lut_vld_q, lut_vld_d, infl_q, infl_d;
  v_pkg::listsize_t cnt_q, cnt_d, ls_q, ls_d;
  ent_t             mem_q [OUT_DEPTH];
  ent_t             mem_d [OUT_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             issue, push, pop;
  ent_t             head;
  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    lvl_d      = lvl_q;
    cnt_d      = cnt_q;
    ls_d       = ls_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    // credits cover the buffer plus both queries whose responses are still due
    issue      = state_q == SCAN && int'(occ_q) + int'(lut_vld_q) + int'(infl_q) < OUT_DEPTH;
    push       = infl_q && !i_lut_error;
    pop        = occ_q != '0 && i_ent_rdy;
    lut_vld_d  = issue;
    lut_lvl_d  = issue ? lvl_q : lut_lvl_q;
    infl_d     = lut_vld_q;
    infl_lvl_d = lut_lvl_q;
    case (state_q)
      IDLE: if (i_req_vld) begin
        state_d = SCAN;
        prod_d  = i_req_prod_id;
        lvl_d   = '0;
        cnt_d   = '0;
        ls_d    = '0;
      end
      SCAN: if (issue) begin
        lvl_d   = lvl_q + 1'b1;
        state_d = lvl_q == v_pkg::level_t'(ENTRIES_N - 1) ? DRAIN : SCAN;
      end
      DRAIN: state_d = !lut_vld_q && !infl_q && occ_q == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (infl_q) ls_d = i_lut_listsize;
    if (push) begin
      mem_d[wr_q] = {infl_lvl_q, i_lut_key, i_lut_size};
      wr_d        = wr_q == PW'(OUT_DEPTH - 1) ? '0 : wr_q + 1'b1;
      cnt_d       = cnt_q == v_pkg::listsize_t'(ENTRIES_N) ? cnt_q : cnt_q + 1'b1;
    end
    if (pop) rd_d = rd_q == PW'(OUT_DEPTH - 1) ? '0 : rd_q + 1'b1;
    occ_d = occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prod_q     <= '0;
      lvl_q      <= '0;
      lut_lvl_q  <= '0;
      infl_lvl_q <= '0;
      lut_vld_q  <= 1'b0;
      infl_q     <= 1'b0;
      cnt_q      <= '0;
      ls_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      assert (!(push && !pop && occ_q == OW'(OUT_DEPTH)));
      state_q    <= state_d;
      prod_q     <= prod_d;
      lvl_q      <= lvl_d;
      lut_lvl_q  <= lut_lvl_d;
      infl_lvl_q <= infl_lvl_d;
      lut_vld_q  <= lut_vld_d;
      infl_q     <= infl_d;
      cnt_q      <= cnt_d;
      ls_q       <= ls_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
      mem_q      <= mem_d;
    end
  end
  assign head            = mem_q[rd_q];
  assign o_req_rdy       = state_q == IDLE;
  assign o_busy          = state_q != IDLE;
  assign o_lut_vld       = lut_vld_q;
  assign o_lut_prod_id   = prod_q;
  assign o_lut_level     = lut_lvl_q;
  assign o_ent_vld       = occ_q != '0;
  assign o_ent_level     = head.level;
  assign o_ent_key       = head.key;
  assign o_ent_size      = head.size;
  assign o_done_vld      = state_q == DONE;
  assign o_done_cnt      = cnt_q;
  assign o_done_mismatch = state_q == DONE && cnt_q != ls_q;
endmodule

// File: tb/tb_v_query_scan.sv
// tb_v_query_scan: randomized scoreboard bench for v_query_scan against a list-level reference model.
module tb_v_query_scan;
  import v_pkg::*;
  localparam int N = ENTRIES_N;
  localparam int D = 4;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic i_req_vld, o_req_rdy, o_lut_vld, i_lut_error, o_ent_vld, i_ent_rdy;
  logic o_done_vld, o_done_mismatch, o_busy;
  id_t i_req_prod_id, o_lut_prod_id;
  level_t o_lut_level, o_ent_level;
  key_t i_lut_key, o_ent_key;
  volume_t i_lut_size, o_ent_size;
  listsize_t i_lut_listsize, o_done_cnt;
  v_query_scan #(.ENTRIES_N(N), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_req_vld(i_req_vld), .i_req_prod_id(i_req_prod_id), .o_req_rdy(o_req_rdy),
    .o_lut_vld(o_lut_vld), .o_lut_prod_id(o_lut_prod_id), .o_lut_level(o_lut_level),
    .i_lut_key(i_lut_key), .i_lut_size(i_lut_size), .i_lut_error(i_lut_error), .i_lut_listsize(i_lut_listsize),
    .o_ent_vld(o_ent_vld), .o_ent_level(o_ent_level), .o_ent_key(o_ent_key), .o_ent_size(o_ent_size),
    .i_ent_rdy(i_ent_rdy), .o_done_vld(o_done_vld), .o_done_cnt(o_done_cnt),
    .o_done_mismatch(o_done_mismatch), .o_busy(o_busy)
  );
  typedef struct packed {level_t l; key_t k; volume_t s;} ent_t;
  int checks = 0, errors = 0;
  bit tv[N], tbz[N];
  key_t tk[N];
  volume_t ts[N];
  listsize_t tl[N];
  ent_t exp_ent[$];
  listsize_t exp_cnt[$];
  bit exp_mis[$];
  int hold = 0, qlvl = 0, acc_cnt = 0, run = 0, max_run = 0;
  id_t cur_id = '0;
  bit rsp_live = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // the lookup pipeline: answers in the cycle after each query from the current list table
  initial begin
    bit qv;
    level_t ql;
    i_lut_key = '0; i_lut_size = '0; i_lut_error = 0; i_lut_listsize = '0;
    forever begin
      @(negedge clk);
      qv = o_lut_vld;
      ql = o_lut_level;
      @(posedge clk);
      #1;
      rsp_live = qv;
      if (qv) begin
        i_lut_key = tk[ql]; i_lut_size = ts[ql]; i_lut_error = !tv[ql] || tbz[ql]; i_lut_listsize = tl[ql];
      end else begin
        i_lut_key = key_t'($urandom); i_lut_size = volume_t'($urandom);
        i_lut_error = 1'($urandom); i_lut_listsize = listsize_t'($urandom);
      end
    end
  end

  // monitor: builds expectations on acceptance, pops and compares on every DUT output
  initial begin
    ent_t e;
    int c;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        hold = 0; qlvl = 0; run = 0;
        exp_ent.delete(); exp_cnt.delete(); exp_mis.delete();
      end else begin
        if (i_req_vld && o_req_rdy) begin
          acc_cnt++; cur_id = i_req_prod_id; qlvl = 0; c = 0;
          for (int l = 0; l < N; l++)
            if (tv[l] && !tbz[l]) begin
              exp_ent.push_back({level_t'(l), tk[l], ts[l]});
              c++;
            end
          exp_cnt.push_back(listsize_t'(c));
          exp_mis.push_back(listsize_t'(c) != tl[N-1]);
        end
        if (o_lut_vld) begin
          chk("query_level", o_lut_level, qlvl);
          chk("query_id", o_lut_prod_id, cur_id);
          qlvl++; run++; hold++;
          if (run > max_run) max_run = run;
          chk("credit_limit", hold <= D, 1);
        end else run = 0;
        if (o_ent_vld && i_ent_rdy) begin
          if (exp_ent.size() == 0) chk("unexpected_entry", o_ent_level, 'x);
          else begin
            e = exp_ent.pop_front();
            chk("ent_level", o_ent_level, e.l);
            chk("ent_key", o_ent_key, e.k);
            chk("ent_size", o_ent_size, e.s);
          end
          if (hold > 0) hold--;
        end
        if (rsp_live && i_lut_error && hold > 0) hold--;
        if (o_done_vld) begin
          if (exp_cnt.size() == 0) chk("unexpected_done", o_done_cnt, 'x);
          else begin
            chk("done_cnt", o_done_cnt, exp_cnt.pop_front());
            chk("done_mismatch", o_done_mismatch, exp_mis.pop_front());
          end
        end
      end
    end
  end

  task automatic set_tab(input logic [N-1:0] v, input logic [N-1:0] b, input listsize_t ls);
    for (int l = 0; l < N; l++) begin
      tv[l] = v[l]; tbz[l] = b[l]; tk[l] = key_t'($urandom); ts[l] = volume_t'($urandom); tl[l] = ls;
    end
  endtask

  task automatic run_scan(input id_t id, input int mode, input bit keep, output int acc_k);
    bit acc = 0, done = 0;
    acc_k = -1;
    max_run = 0;
    @(posedge clk); #1;
    i_req_vld = 1; i_req_prod_id = id;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = o_req_rdy;
      acc_k = k;
    end
    if (!acc) chk("req_accept_timeout", 0, 1);
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      if (!keep) i_req_vld = 0;
      i_ent_rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : !(k >= 1 && k <= 11);
      @(negedge clk);
      done = o_done_vld;
    end
    if (!done) chk("done_timeout", 0, 1);
    #1;
    chk("no_entries_left", exp_ent.size(), 0);
  endtask

  initial begin
    int ak, a0;
    logic [N-1:0] v;
    i_req_vld = 0; i_req_prod_id = '0; i_ent_rdy = 0;
    set_tab('0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", o_req_rdy, 1);
    chk("rst_lut_vld", o_lut_vld, 0);
    chk("rst_ent_vld", o_ent_vld, 0);
    chk("rst_done_vld", o_done_vld, 0);
    chk("rst_done_cnt", o_done_cnt, 0);
    chk("rst_done_mismatch", o_done_mismatch, 0);
    chk("rst_busy", o_busy, 0);
    #2 rst = 1;
    set_tab(16'h0025, '0, 3);
    run_scan(3, 0, 0, ak);
    chk("full_rate_query_run", max_run, N);
    set_tab(16'h0025, '0, 3);
    run_scan(3, 2, 0, ak);
    set_tab(16'h0025, 16'h0004, 3);
    run_scan(3, 0, 0, ak);
    set_tab('0, '0, 0);
    run_scan(7, 1, 0, ak);
    @(negedge clk);
    chk("empty_rdy_after_done", o_req_rdy, 1);
    set_tab(16'hffff, '0, 16);
    @(posedge clk); #1;
    i_req_vld = 1; i_req_prod_id = 5; i_ent_rdy = 1;
    @(negedge clk);
    chk("abort_accept", o_req_rdy, 1);
    @(posedge clk); #1;
    i_req_vld = 0;
    ak = 0;
    for (int k = 0; k < 100 && !(o_lut_vld && o_lut_level == 7); k++) @(negedge clk);
    chk("abort_reached_level7", o_lut_vld && o_lut_level == 7, 1);
    #2 rst = 0;
    #1;
    chk("abort_req_rdy", o_req_rdy, 1);
    chk("abort_lut_vld", o_lut_vld, 0);
    chk("abort_ent_vld", o_ent_vld, 0);
    chk("abort_done_vld", o_done_vld, 0);
    chk("abort_busy", o_busy, 0);
    @(posedge clk); #3 rst = 1;
    set_tab(16'h8421, '0, 4);
    run_scan(9, 0, 0, ak);
    set_tab(16'h1234, '0, 5);
    a0 = acc_cnt;
    run_scan(11, 0, 1, ak);
    chk("held_single_accept", acc_cnt - a0, 1);
    run_scan(11, 1, 0, ak);
    chk("held_accept_after_done", ak, 0);
    chk("held_second_accept", acc_cnt - a0, 2);
    repeat (10) begin
      v = N'($urandom);
      set_tab(v, N'($urandom & $urandom & $urandom),
              listsize_t'($countones(v) + ($urandom_range(0, 3) == 0 ? 1 : 0)));
      run_scan(id_t'($urandom), $urandom_range(0, 1), 0, ak);
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
